// File: rtl/mc_cu.sv
// Multi-cycle control unit for a MIPS subset: IF/ID/EXE/MEM/WB sequencing over one shared
// memory port, with either ready-handshaked or fixed-latency memory accesses.
module mc_cu #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_LAT       = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       wir,
    output logic       wpc,
    output logic [1:0] pcsource,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       wmem,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       aluimm,
    output logic       sext,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic legal;

    assign r_type = (op == 6'b000000);
    assign i_add  = r_type & (func == 6'b100000);
    assign i_sub  = r_type & (func == 6'b100010);
    assign i_and  = r_type & (func == 6'b100100);
    assign i_or   = r_type & (func == 6'b100101);
    assign i_xor  = r_type & (func == 6'b100110);
    assign i_sll  = r_type & (func == 6'b000000);
    assign i_srl  = r_type & (func == 6'b000010);
    assign i_sra  = r_type & (func == 6'b000011);
    assign i_jr   = r_type & (func == 6'b001000);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_lui  = (op == 6'b001111);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    assign legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                   i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne |
                   i_lui | i_j | i_jal;

    // In handshake mode the counter still runs but only mem_ready ends an access.
    assign done  = (MEM_HANDSHAKE != 0) ? mem_ready : (cnt_q == LAT_LAST);
    assign state = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = done ? S_ID : S_IF;
            S_ID:  state_d = (i_j | i_jal | i_jr | ~legal) ? S_IF : S_EXE;
            S_EXE: begin
                if (i_beq | i_bne)    state_d = S_IF;
                else if (i_lw | i_sw) state_d = S_MEM;
                else                  state_d = S_WB;
            end
            S_MEM: begin
                if (!done)     state_d = S_MEM;
                else if (i_sw) state_d = S_IF;
                else           state_d = S_WB;
            end
            default: state_d = S_IF;
        endcase

        cnt_d = '0;
        if (((state_q == S_IF) || (state_q == S_MEM)) && !done && (state_d == state_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        mem_req  = 1'b0;
        iord     = 1'b0;
        wir      = 1'b0;
        wpc      = 1'b0;
        pcsource = 2'b00;
        wreg     = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        wmem     = 1'b0;
        illegal  = 1'b0;

        regrt   = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
        shift   = i_sll | i_srl | i_sra;
        aluimm  = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
        sext    = i_addi | i_lw | i_sw | i_beq | i_bne;
        aluc[3] = i_sra;
        aluc[2] = i_sub | i_or | i_srl | i_sra | i_ori | i_lui | i_beq | i_bne;
        aluc[1] = i_xor | i_sll | i_srl | i_sra | i_xori | i_lui;
        aluc[0] = i_and | i_or | i_sll | i_srl | i_sra | i_andi | i_ori;

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                wir     = done;
                wpc     = done;
            end
            S_ID: begin
                if (i_j | i_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = i_jal;
                    jal      = i_jal;
                end else if (i_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end
                illegal = ~legal;
            end
            S_EXE: begin
                if (i_beq | i_bne) begin
                    wpc      = i_beq ? z : ~z;
                    pcsource = 2'b01;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = i_sw;
            end
            S_WB: begin
                wreg  = 1'b1;
                m2reg = i_lw;
            end
            default: ;
        endcase

        // Reset abandons any access in flight this very cycle.
        if (reset) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wreg    = 1'b0;
            wmem    = 1'b0;
            mem_req = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Bench for mc_cu: a handshake instance and a fixed-latency (MEM_LAT=3) instance driven
// cycle by cycle, with per-cycle expected control words queued and compared.
module tb_mc_cu;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic        rst;
        logic [21:0] e;
    } step_t;

    // decoded-field bundles {regrt, aluc[3:0], shift, aluimm, sext}
    localparam logic [7:0] D_ADD = 8'b0_0000_000;
    localparam logic [7:0] D_SLL = 8'b0_0011_100;
    localparam logic [7:0] D_LW  = 8'b1_0000_011;
    localparam logic [7:0] D_SW  = 8'b0_0000_011;
    localparam logic [7:0] D_BR  = 8'b0_0100_001;
    localparam logic [7:0] D_NON = 8'b0_0000_000;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    int checks = 0;
    int failures = 0;
    logic [21:0] sb[$];

    logic       reset_h, z_h, rdy_h;
    logic [5:0] op_h, func_h;
    logic       mem_req_h, iord_h, wir_h, wpc_h, wreg_h, regrt_h, m2reg_h, jal_h, wmem_h;
    logic       shift_h, aluimm_h, sext_h, illegal_h;
    logic [1:0] pcsource_h;
    logic [3:0] aluc_h;
    logic [2:0] state_h;

    logic       reset_f, z_f, rdy_f;
    logic [5:0] op_f, func_f;
    logic       mem_req_f, iord_f, wir_f, wpc_f, wreg_f, regrt_f, m2reg_f, jal_f, wmem_f;
    logic       shift_f, aluimm_f, sext_f, illegal_f;
    logic [1:0] pcsource_f;
    logic [3:0] aluc_f;
    logic [2:0] state_f;

    mc_cu #(.MEM_HANDSHAKE(1), .MEM_LAT(1), .CNT_W(4)) dut_h (
        .clock(clock), .reset(reset_h), .op(op_h), .func(func_h), .z(z_h), .mem_ready(rdy_h),
        .mem_req(mem_req_h), .iord(iord_h), .wir(wir_h), .wpc(wpc_h), .pcsource(pcsource_h),
        .wreg(wreg_h), .regrt(regrt_h), .m2reg(m2reg_h), .jal(jal_h), .wmem(wmem_h),
        .aluc(aluc_h), .shift(shift_h), .aluimm(aluimm_h), .sext(sext_h),
        .illegal(illegal_h), .state(state_h)
    );

    mc_cu #(.MEM_HANDSHAKE(0), .MEM_LAT(3), .CNT_W(4)) dut_f (
        .clock(clock), .reset(reset_f), .op(op_f), .func(func_f), .z(z_f), .mem_ready(rdy_f),
        .mem_req(mem_req_f), .iord(iord_f), .wir(wir_f), .wpc(wpc_f), .pcsource(pcsource_f),
        .wreg(wreg_f), .regrt(regrt_f), .m2reg(m2reg_f), .jal(jal_f), .wmem(wmem_f),
        .aluc(aluc_f), .shift(shift_f), .aluimm(aluimm_f), .sext(sext_f),
        .illegal(illegal_f), .state(state_f)
    );

    wire logic [21:0] obs_h = {state_h, mem_req_h, iord_h, wir_h, wpc_h, pcsource_h, wreg_h,
                               regrt_h, m2reg_h, jal_h, wmem_h, aluc_h, shift_h, aluimm_h,
                               sext_h, illegal_h};
    wire logic [21:0] obs_f = {state_f, mem_req_f, iord_f, wir_f, wpc_f, pcsource_f, wreg_f,
                               regrt_f, m2reg_f, jal_f, wmem_f, aluc_f, shift_f, aluimm_f,
                               sext_f, illegal_f};

    function automatic logic [21:0] ex(input logic [2:0] st, input logic mreq, input logic io,
                                       input logic wi, input logic wp, input logic [1:0] pcs,
                                       input logic wr, input logic m2, input logic jl,
                                       input logic wm, input logic ill, input logic [7:0] d);
        return {st, mreq, io, wi, wp, pcs, wr, d[7], m2, jl, wm, d[6:3], d[2], d[1], d[0], ill};
    endfunction

    function automatic step_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic rdy, input logic rst, input logic [21:0] e);
        step_t s;
        s.op = op; s.fn = fn; s.z = z; s.rdy = rdy; s.rst = rst; s.e = e;
        return s;
    endfunction

    task automatic test_reset();
        logic [21:0] want;
        reset_h = 1'b1; reset_f = 1'b1;
        op_h = OP_R; func_h = 6'b100000; z_h = 1'b0; rdy_h = 1'b1;
        op_f = OP_SW; func_f = 6'b000000; z_f = 1'b0; rdy_f = 1'b1;
        repeat (2) @(posedge clock);
        sb.push_back(ex(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_ADD));
        sb.push_back(ex(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SW));
        @(negedge clock);
        want = sb.pop_front(); checks++;
        if (obs_h !== want) begin
            failures++; $display("FAIL reset_h got=%h want=%h", obs_h, want);
        end
        want = sb.pop_front(); checks++;
        if (obs_f !== want) begin
            failures++; $display("FAIL reset_f got=%h want=%h", obs_f, want);
        end
        @(posedge clock); #1;
        reset_h = 1'b0;
    endtask

    task automatic test_alu();
        step_t s[8];
        logic [21:0] want;
        s[0] = mk(OP_R, 6'b100000, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_ADD));
        s[1] = mk(OP_R, 6'b100000, 0, 1, 0, ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_ADD));
        s[2] = mk(OP_R, 6'b100000, 1, 1, 0, ex(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_ADD));
        s[3] = mk(OP_R, 6'b100000, 0, 1, 0, ex(3'd4, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, D_ADD));
        s[4] = mk(OP_R, 6'b000000, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_SLL));
        s[5] = mk(OP_R, 6'b000000, 0, 0, 0, ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SLL));
        s[6] = mk(OP_R, 6'b000000, 0, 0, 0, ex(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SLL));
        s[7] = mk(OP_R, 6'b000000, 0, 0, 0, ex(3'd4, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, D_SLL));
        for (int i = 0; i < 8; i++) begin
            op_h = s[i].op; func_h = s[i].fn; z_h = s[i].z; rdy_h = s[i].rdy; reset_h = s[i].rst;
            sb.push_back(s[i].e);
            @(negedge clock);
            want = sb.pop_front(); checks++;
            if (obs_h !== want) begin
                failures++; $display("FAIL alu[%0d] got=%h want=%h", i, obs_h, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_lw_wait();
        step_t s[9];
        logic [21:0] want;
        s[0] = mk(OP_LW, 6'd0, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_LW));
        s[1] = mk(OP_LW, 6'd0, 0, 0, 0, ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_LW));
        s[2] = mk(OP_LW, 6'd0, 0, 1, 0, ex(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_LW));
        for (int i = 3; i < 7; i++)
            s[i] = mk(OP_LW, 6'd0, 0, (i == 6), 0, ex(3'd3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_LW));
        s[7] = mk(OP_LW, 6'd0, 0, 0, 0, ex(3'd4, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, D_LW));
        s[8] = mk(OP_LW, 6'd0, 0, 0, 0, ex(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_LW));
        for (int i = 0; i < 9; i++) begin
            op_h = s[i].op; func_h = s[i].fn; z_h = s[i].z; rdy_h = s[i].rdy; reset_h = s[i].rst;
            sb.push_back(s[i].e);
            @(negedge clock);
            want = sb.pop_front(); checks++;
            if (obs_h !== want) begin
                failures++; $display("FAIL lw[%0d] got=%h want=%h", i, obs_h, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        step_t s[13];
        logic [21:0] want;
        logic [5:0] bop;
        logic bz, take;
        for (int k = 0; k < 4; k++) begin
            bop  = (k % 2 == 0) ? OP_BEQ : OP_BNE;
            bz   = (k < 2);
            take = (bop == OP_BEQ) ? bz : ~bz;
            s[3*k]   = mk(bop, 6'd0, bz, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_BR));
            s[3*k+1] = mk(bop, 6'd0, bz, 1, 0, ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_BR));
            s[3*k+2] = mk(bop, 6'd0, bz, 1, 0, ex(3'd2, 0, 0, 0, take, 2'b01, 0, 0, 0, 0, 0, D_BR));
        end
        s[12] = mk(OP_BNE, 6'd0, 0, 0, 0, ex(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_BR));
        for (int i = 0; i < 13; i++) begin
            op_h = s[i].op; func_h = s[i].fn; z_h = s[i].z; rdy_h = s[i].rdy; reset_h = s[i].rst;
            sb.push_back(s[i].e);
            @(negedge clock);
            want = sb.pop_front(); checks++;
            if (obs_h !== want) begin
                failures++; $display("FAIL branch[%0d] got=%h want=%h", i, obs_h, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_jump();
        step_t s[7];
        logic [21:0] want;
        s[0] = mk(OP_JAL, 6'd0, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_NON));
        s[1] = mk(OP_JAL, 6'd0, 0, 1, 0, ex(3'd1, 0, 0, 0, 1, 2'b11, 1, 0, 1, 0, 0, D_NON));
        s[2] = mk(OP_R, 6'b001000, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_NON));
        s[3] = mk(OP_R, 6'b001000, 0, 1, 0, ex(3'd1, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0, D_NON));
        s[4] = mk(OP_J, 6'd0, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_NON));
        s[5] = mk(OP_J, 6'd0, 0, 1, 0, ex(3'd1, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0, D_NON));
        s[6] = mk(OP_J, 6'd0, 0, 0, 0, ex(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_NON));
        for (int i = 0; i < 7; i++) begin
            op_h = s[i].op; func_h = s[i].fn; z_h = s[i].z; rdy_h = s[i].rdy; reset_h = s[i].rst;
            sb.push_back(s[i].e);
            @(negedge clock);
            want = sb.pop_front(); checks++;
            if (obs_h !== want) begin
                failures++; $display("FAIL jump[%0d] got=%h want=%h", i, obs_h, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_illegal();
        step_t s[5];
        logic [21:0] want;
        s[0] = mk(OP_BAD, 6'd0, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_NON));
        s[1] = mk(OP_BAD, 6'd0, 1, 1, 0, ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, D_NON));
        s[2] = mk(OP_R, 6'b000001, 0, 1, 0, ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_NON));
        s[3] = mk(OP_R, 6'b000001, 0, 1, 0, ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, D_NON));
        s[4] = mk(OP_R, 6'b000001, 0, 0, 0, ex(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_NON));
        for (int i = 0; i < 5; i++) begin
            op_h = s[i].op; func_h = s[i].fn; z_h = s[i].z; rdy_h = s[i].rdy; reset_h = s[i].rst;
            sb.push_back(s[i].e);
            @(negedge clock);
            want = sb.pop_front(); checks++;
            if (obs_h !== want) begin
                failures++; $display("FAIL illegal[%0d] got=%h want=%h", i, obs_h, want);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_fixed_latency();
        step_t s[18];
        logic [21:0] want;
        logic [21:0] if_wait, if_done, id_e, exe_e, mem_e;
        if_wait = ex(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SW);
        if_done = ex(3'd0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, D_SW);
        id_e    = ex(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SW);
        exe_e   = ex(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SW);
        mem_e   = ex(3'd3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, D_SW);
        // mem_ready held high throughout: it must have no effect in this mode
        s[0]  = mk(OP_SW, 6'd0, 0, 1, 0, if_wait);
        s[1]  = mk(OP_SW, 6'd0, 0, 1, 0, if_wait);
        s[2]  = mk(OP_SW, 6'd0, 0, 1, 0, if_done);
        s[3]  = mk(OP_SW, 6'd0, 0, 1, 0, id_e);
        s[4]  = mk(OP_SW, 6'd0, 0, 1, 0, exe_e);
        s[5]  = mk(OP_SW, 6'd0, 0, 1, 0, mem_e);
        s[6]  = mk(OP_SW, 6'd0, 0, 1, 0, mem_e);
        s[7]  = mk(OP_SW, 6'd0, 0, 1, 0, mem_e);
        s[8]  = mk(OP_SW, 6'd0, 0, 1, 0, if_wait);
        s[9]  = mk(OP_SW, 6'd0, 0, 1, 0, if_wait);
        s[10] = mk(OP_SW, 6'd0, 0, 1, 0, if_done);
        s[11] = mk(OP_SW, 6'd0, 0, 1, 0, id_e);
        s[12] = mk(OP_SW, 6'd0, 0, 1, 0, exe_e);
        s[13] = mk(OP_SW, 6'd0, 0, 1, 0, mem_e);
        s[14] = mk(OP_SW, 6'd0, 0, 1, 1, ex(3'd3, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, D_SW));
        s[15] = mk(OP_SW, 6'd0, 0, 1, 0, if_wait);
        s[16] = mk(OP_SW, 6'd0, 0, 1, 0, if_wait);
        s[17] = mk(OP_SW, 6'd0, 0, 1, 0, if_done);
        for (int i = 0; i < 18; i++) begin
            op_f = s[i].op; func_f = s[i].fn; z_f = s[i].z; rdy_f = s[i].rdy; reset_f = s[i].rst;
            sb.push_back(s[i].e);
            @(negedge clock);
            want = sb.pop_front(); checks++;
            if (obs_f !== want) begin
                failures++; $display("FAIL fixed[%0d] got=%h want=%h", i, obs_f, want);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_branch();
        test_jump();
        test_illegal();
        test_fixed_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
